prim_slice_packer: RTL

Sequential inverse of the slicer primitive: accepts a stream of narrow `InW`-bit chunks over a valid/ready handshake and assembles them, least-significant chunk first, into one `OutW`-bit word. A word is emitted when `NumChunks = ceil(OutW/InW)` chunks are collected, or earlier on an end-of-message marker. Unfilled upper bits are zero, which mirrors the slicer's zero-fill of fractional messages. The block sits on the receive side of serialised datapaths, such as byte streams feeding 64-bit hash or key registers.

---
 rtl/prim_slice_packer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/prim_slice_packer.sv
// prim_slice_packer: assembles a stream of InW-bit chunks, least-significant
// chunk first, into one OutW-bit word. Unwritten upper bits read as zero.
// Optional feature macro: PRIM_SLICE_PACKER_LAST_EN. When it is defined,
// last_i closes a word early and last_o reports it. When it is undefined,
// last_i is ignored and last_o is 0.
module prim_slice_packer #(
  parameter int unsigned InW  = 8,
  parameter int unsigned OutW = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [InW-1:0]  data_i,
  input  logic            last_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [OutW-1:0] data_o,
  output logic            last_o
);

  localparam int unsigned NumChunks = (OutW + InW - 1) / InW;
  localparam int unsigned CntW      = $clog2(NumChunks + 1);
  localparam int unsigned BufW      = NumChunks * InW;

`ifdef PRIM_SLICE_PACKER_LAST_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [BufW-1:0] buf_q, buf_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt;
  logic            last_q, last_d;
  logic            valid_q;
  logic            acc;
  logic            clear;
  logic            close;
  logic            unused_buf;

  assign valid_q = (state_q == HOLD);

  // ready_o depends only on the held word and ready_i, never on valid_i
  assign ready_o = !valid_q || ready_i;
  assign acc     = valid_i && ready_o;
  assign clear   = valid_q && ready_i;

  assign valid_o = valid_q;
  assign data_o  = buf_q[OutW-1:0];
  assign last_o  = LastEn ? last_q : 1'b0;

  // Bits of the final chunk above OutW are stored but never read
  assign unused_buf = ^buf_q;

  // State register; reset discards any partial or held word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next state: output handshake clears the buffer, then an accept writes into it
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cnt     = cnt_q;
    close   = 1'b0;

    if (clear) begin
      state_d = FILL;
      buf_d   = '0;
      cnt     = '0;
      cnt_d   = '0;
      last_d  = 1'b0;
    end

    if (acc) begin
      for (int unsigned i = 0; i < NumChunks; i++) begin
        if (cnt == CntW'(i)) begin
          buf_d[i*InW +: InW] = data_i;
        end
      end
      close = (cnt == CntW'(NumChunks - 1)) || (LastEn && last_i);
      if (close) begin
        state_d = HOLD;
        cnt_d   = '0;
        last_d  = LastEn && last_i;
      end else begin
        state_d = FILL;
        cnt_d   = cnt + CntW'(1);
      end
    end
  end

  // Parameter sanity: a chunk may not be wider than the word
  always_comb begin
    ValidWidth_A: assert (InW <= OutW);
  end

  // A stalled word must stay put until the downstream takes it
  DataStable_A: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o) && $stable(last_o)));

endmodule
